// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_pkg
// Description : Shared constants and types for the pushbutton/switch input
//               conditioner. It holds the FSM state encoding, the default
//               debounce length and the switch bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package input_conditioner_pkg;

    // Default debounce length in synchronized samples (1 ms at 50 MHz)
    localparam int unsigned c_debounce_cycles_default = 50000;

    // Width of the board switch bus
    localparam int unsigned c_sw_width = 16;

    // Debounce FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

endpackage : input_conditioner_pkg
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_if
// Description : Bundle of board-side inputs and CPU-side outputs of the
//               input conditioner.
//               master : drives button_raw/switches_raw, observes the outputs
//               slave  : the conditioner itself
//   button_raw   raw bouncing pushbutton level (1 = pressed)
//   switches_raw raw board switch levels
//   ready        one-cycle pulse per accepted press
//   switches     switch snapshot captured on the accepted press
//   pressed      debounced button level
// Revision    : 1.0 - initial release
// ============================================================================
interface input_conditioner_if;
    import input_conditioner_pkg::*;

    logic                  button_raw;
    logic [c_sw_width-1:0] switches_raw;
    logic                  ready;
    logic [c_sw_width-1:0] switches;
    logic                  pressed;

    modport master (
        output button_raw,
        output switches_raw,
        input  ready,
        input  switches,
        input  pressed
    );

    modport slave (
        input  button_raw,
        input  switches_raw,
        output ready,
        output switches,
        output pressed
    );

endinterface : input_conditioner_if
`default_nettype wire

// File: rtl/input_conditioner_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Width-parameterized two-flop synchronizer. Each bit is
//               synchronized independently.
//   clk    system clock
//   reset  synchronous active-high reset, clears both stages
//   d_i    asynchronous input
//   q_o    synchronized output, visible two rising edges after d_i settles
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Synchronizes and debounces a pushbutton and synchronizes the
//               board switches. Every accepted press produces one ready pulse
//               and captures a snapshot of the switches for the CPU.
//   clk      system clock, all state updates on the rising edge
//   reset    synchronous active-high reset
//   bus      slave side of input_conditioner_if
//            (button_raw, switches_raw in; ready, switches, pressed out)
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
    input  logic                  clk,
    input  logic                  reset,
    input_conditioner_if.slave    bus
);

    // The counter only ever reaches N-1, so clog2(N+1) bits is ample.
    localparam int unsigned            c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]     c_cnt_one  = c_cnt_w'(1);

    logic                  btn_s;
    logic [c_sw_width-1:0] sw_s;

    state_e                state_q, state_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [c_sw_width-1:0] switches_q, switches_d;
    logic                  pressed_q, pressed_d;

    sync2 #(.WIDTH(1)) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.button_raw),
        .q_o   (btn_s)
    );

    sync2 #(.WIDTH(c_sw_width)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.switches_raw),
        .q_o   (sw_s)
    );

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            switches_q <= '0;
            pressed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            switches_q <= switches_d;
            pressed_q  <= pressed_d;
        end
    end

    // Next-state and debounce counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == c_cnt_last) begin
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back to 1 returns to PRESSED silently; only the
                // IDLE path can generate another pulse.
                if (btn_s) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == c_cnt_last) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values; registered above so no raw input reaches an output
    // combinationally.
    always_comb begin
        ready_d    = 1'b0;
        switches_d = switches_q;
        pressed_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
        if ((state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED)) begin
            ready_d    = 1'b1;
            switches_d = sw_s;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.switches = switches_q;
    assign bus.pressed  = pressed_q;

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner with a debounce
//               length of 4. A per-cycle vector table covers reset, a clean
//               press, snapshot hold, release and a second press; directed
//               sequences cover bounces, glitches and reset mid-debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;
    import input_conditioner_pkg::*;

    typedef struct {
        logic        rst;
        logic        btn;
        logic [15:0] sw;
        logic        exp_ready;
        logic        exp_pressed;
        logic [15:0] exp_sw;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    input_conditioner_if bus ();

    input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   pulses     = 0;
    int   last_pulse = -1;
    logic prev_ready = 1'b0;
    int   p0;
    int   rise;

    function automatic void add(input logic r, input logic b, input logic [15:0] s,
                                input logic er, input logic ep, input logic [15:0] es,
                                input int n);
        vec_t v;
        v.rst = r; v.btn = b; v.sw = s;
        v.exp_ready = er; v.exp_pressed = ep; v.exp_sw = es;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Apply inputs, advance one clock, sample 1 ns after the edge.
    task automatic tick(input logic r, input logic b, input logic [15:0] s);
        reset            = r;
        bus.button_raw   = b;
        bus.switches_raw = s;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (bus.ready && prev_ready) begin
            failures++;
            $display("FAIL ready_double at cycle %0d: got ready high twice, expected single pulse", cyc);
        end
        prev_ready = bus.ready;
        if (bus.ready) begin
            pulses++;
            last_pulse = cyc;
        end
    endtask

    task automatic hold(input logic b, input logic [15:0] s, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, b, s);
    endtask

    initial begin
        reset            = 1'b1;
        bus.button_raw   = 1'b0;
        bus.switches_raw = 16'h0000;

        // ---------------- table: clean press, snapshot, release, re-press
        add(1, 0, 16'hA5A5, 0, 0, 16'h0000, 2);
        add(0, 1, 16'hA5A5, 0, 0, 16'h0000, 6);
        add(0, 1, 16'hA5A5, 1, 1, 16'hA5A5, 1);
        add(0, 1, 16'h1234, 0, 1, 16'hA5A5, 4);
        add(0, 0, 16'h1234, 0, 1, 16'hA5A5, 6);
        add(0, 0, 16'h1234, 0, 0, 16'hA5A5, 3);
        add(0, 1, 16'h1234, 0, 0, 16'hA5A5, 6);
        add(0, 1, 16'h1234, 1, 1, 16'h1234, 1);
        add(0, 1, 16'h1234, 0, 1, 16'h1234, 2);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].btn, vecs[i].sw);
            chk("vec_ready",    bus.ready,    vecs[i].exp_ready);
            chk("vec_pressed",  bus.pressed,  vecs[i].exp_pressed);
            chk("vec_switches", bus.switches, vecs[i].exp_sw);
        end

        // ---------------- press bounce: 1x3, 0x1, then held
        hold(1'b0, 16'h1234, 10);
        chk("bounce_idle_pressed", bus.pressed, 0);
        p0 = pulses;
        hold(1'b1, 16'h1234, 3);
        hold(1'b0, 16'h1234, 1);
        rise = cyc + 1;
        hold(1'b1, 16'h1234, 12);
        chk("bounce_pulse_count", pulses - p0, 1);
        chk("bounce_latency",     last_pulse - rise + 1, 7);
        chk("bounce_pressed",     bus.pressed, 1);

        // ---------------- release bounce: 0x2 then 1, pressed must hold
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, (i < 2) ? 1'b0 : 1'b1, 16'h1234);
            chk("relbounce_pressed", bus.pressed, 1);
        end
        hold(1'b0, 16'h1234, 10);
        chk("release_pressed",    bus.pressed, 0);
        chk("release_no_pulse",   pulses - p0, 0);
        p0 = pulses;
        rise = cyc + 1;
        hold(1'b1, 16'h1234, 10);
        chk("repress_pulse_count", pulses - p0, 1);
        chk("repress_latency",     last_pulse - rise + 1, 7);
        hold(1'b0, 16'h1234, 10);

        // ---------------- short glitch: 1x2 then 0
        p0 = pulses;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, (i < 2) ? 1'b1 : 1'b0, 16'h1234);
            chk("glitch_pressed", bus.pressed, 0);
        end
        chk("glitch_no_pulse", pulses - p0, 0);

        // ---------------- reset at cnt=2 in PRESS_WAIT, button kept high
        p0 = pulses;
        hold(1'b1, 16'hBEEF, 5);
        tick(1'b1, 1'b1, 16'hBEEF);
        tick(1'b1, 1'b1, 16'hBEEF);
        chk("rst_ready",    bus.ready,    0);
        chk("rst_pressed",  bus.pressed,  0);
        chk("rst_switches", bus.switches, 16'h0000);
        chk("rst_no_pulse", pulses - p0,  0);
        rise = cyc + 1;
        hold(1'b1, 16'hBEEF, 10);
        chk("post_rst_pulse_count", pulses - p0, 1);
        chk("post_rst_latency",     last_pulse - rise + 1, 7);
        chk("post_rst_switches",    bus.switches, 16'hBEEF);
        chk("post_rst_pressed",     bus.pressed,  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_input_conditioner
`default_nettype wire
